// File: rtl/bcd_down_counter.sv
// ============================================================================
// Module   : bcd_down_counter
// Purpose  : Multi-digit BCD countdown counter with load, start/stop, and a
//            zero-reached Done pulse.
// Option   : define BCD_WRAP_EN to wrap 0 -> all-9s and emit a Bout pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_down_counter #(
  parameter int DIGITS = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] LoadData,
  input  logic                Start,
  input  logic                Stop,
  input  logic                Trigger,
  input  logic                Bin,
  output logic [4*DIGITS-1:0] DataOut,
  output logic                Zero,
  output logic                Busy,
  output logic                Done,
  output logic                Bout
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   count, count_nxt;
  logic [W-1:0]   clamped, decremented;
  logic           done_q, done_nxt;
  logic           bout_q, bout_nxt;
  logic           tick;
  logic           is_zero;
  logic           borrow;

  assign tick    = Trigger | Bin;
  assign is_zero = (count == '0);

  // Out-of-range preset digits saturate at 9 so the count is always valid BCD.
  always_comb begin
    clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      clamped[4*i +: 4] = (LoadData[4*i +: 4] > 4'd9) ? 4'd9 : LoadData[4*i +: 4];
    end
  end

  // Full-width borrow ripple; an all-zero count naturally becomes all nines.
  always_comb begin
    decremented = '0;
    borrow      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          decremented[4*i +: 4] = 4'd9;
        end else begin
          decremented[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow                = 1'b0;
        end
      end else begin
        decremented[4*i +: 4] = count[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    bout_nxt  = 1'b0;
    if (Load) begin
      count_nxt = clamped;
      state_nxt = IDLE;
    end else if (Stop) begin
      state_nxt = IDLE;
    end else if (Start) begin
      if (state == IDLE) begin
        if (!is_zero) begin
          state_nxt = RUN;
        end else begin
`ifdef BCD_WRAP_EN
          state_nxt = RUN;
`else
          done_nxt  = 1'b1;
`endif
        end
      end
    end else if (tick && (state == RUN)) begin
`ifdef BCD_WRAP_EN
      count_nxt = decremented;
      if (is_zero) begin
        bout_nxt = 1'b1;
      end else if (decremented == '0) begin
        done_nxt = 1'b1;
      end
`else
      if (is_zero) begin
        state_nxt = IDLE;
      end else begin
        count_nxt = decremented;
        if (decremented == '0) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      count  <= '0;
      done_q <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      done_q <= done_nxt;
      bout_q <= bout_nxt;
    end
  end

  assign DataOut = count;
  assign Zero    = is_zero;
  assign Busy    = (state == RUN);
  assign Done    = done_q;
  assign Bout    = bout_q;

endmodule

`default_nettype wire
